// File: rtl/wptr_full_gen.sv
// Write-side pointer and flag generator for an asynchronous FIFO.
// Keeps the binary/Gray write pointer and synchronizes the read pointer
// into the write clock domain. Full, almost-full, fill level and a sticky
// overflow flag are derived from the synchronized read pointer.
// The full flag is pessimistic: it clears only after a read-pointer move
// has crossed the two-flop synchronizer.
module wptr_full_gen #(
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [ADDR_BITS:0]   rptr_gray,
  output logic                 wen,
  output logic [ADDR_BITS-1:0] waddr,
  output logic [ADDR_BITS:0]   wptr_gray,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_BITS:0]   wlevel,
  output logic                 overflow
);

  localparam int PW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] AF_THRESH = PW'(AF_LEVEL);

  // Binary to reflected Gray code.
  function automatic logic [ADDR_BITS:0] bin2gray(input logic [ADDR_BITS:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Reflected Gray code to binary: each bit is the XOR of itself and all higher Gray bits.
  function automatic logic [ADDR_BITS:0] gray2bin(input logic [ADDR_BITS:0] g);
    logic [ADDR_BITS:0] b;
    b = {PW{1'b0}};
    for (int i = 0; i <= ADDR_BITS; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [ADDR_BITS:0] rq1_q;
  logic [ADDR_BITS:0] rq2_q;
  logic [ADDR_BITS:0] wbin_q,     wbin_d;
  logic [ADDR_BITS:0] wgray_q,    wgray_d;
  logic               wfull_q,    wfull_d;
  logic               waf_q,      waf_d;
  logic [ADDR_BITS:0] wlevel_q,   wlevel_d;
  logic               overflow_q, overflow_d;
  logic               wr_accept;
  logic [ADDR_BITS:0] rbin_sync;

  // Two-flop synchronizer for the read pointer; nothing may sit between rq1 and rq2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rq1_q <= {PW{1'b0}};
      rq2_q <= {PW{1'b0}};
    end else begin
      rq1_q <= rptr_gray;
      rq2_q <= rq1_q;
    end
  end

  // Next-state pointer arithmetic and flag evaluation against the synchronized read pointer.
  always_comb begin
    wr_accept  = winc & ~wfull_q;
    wbin_d     = wbin_q + PW'(wr_accept);
    wgray_d    = bin2gray(wbin_d);
    rbin_sync  = gray2bin(rq2_q);
    wlevel_d   = wbin_d - rbin_sync;
    // Full when the pointers match except for the two MSBs (wrapped exactly once).
    wfull_d    = (wgray_d == {~rq2_q[ADDR_BITS:ADDR_BITS-1], rq2_q[ADDR_BITS-2:0]});
    waf_d      = (wlevel_d >= AF_THRESH);
    overflow_d = overflow_q | (winc & wfull_q);
  end

  // Pointer and flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_q     <= {PW{1'b0}};
      wgray_q    <= {PW{1'b0}};
      wfull_q    <= 1'b0;
      waf_q      <= 1'b0;
      wlevel_q   <= {PW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      wfull_q    <= wfull_d;
      waf_q      <= waf_d;
      wlevel_q   <= wlevel_d;
      overflow_q <= overflow_d;
    end
  end

  // The write strobe and address are forced low during reset so that memory is never written then.
  assign wen          = wr_accept & rst_n;
  assign waddr        = wbin_q[ADDR_BITS-1:0] & {ADDR_BITS{rst_n}};
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wlevel       = wlevel_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Scoreboard bench for wptr_full_gen (ADDR_BITS=4, AF_LEVEL=14).
// The driver applies one cycle of inputs just after a rising edge and queues
// the outputs it expects to see during that cycle. A separate monitor pops
// one entry at every falling edge and compares the entry with the DUT outputs.
module tb_wptr_full_gen;

  localparam logic [7:0] M_WEN  = 8'h01;
  localparam logic [7:0] M_ADDR = 8'h02;
  localparam logic [7:0] M_GRAY = 8'h04;
  localparam logic [7:0] M_FULL = 8'h08;
  localparam logic [7:0] M_AF   = 8'h10;
  localparam logic [7:0] M_LVL  = 8'h20;
  localparam logic [7:0] M_OVF  = 8'h40;
  localparam logic [7:0] M_STEP = 8'h80;
  localparam logic [7:0] M_ALL  = 8'h7f;

  typedef struct {
    int         cyc;
    logic [7:0] m;
    logic       wen;
    logic [3:0] addr;
    logic [4:0] gray;
    logic       full;
    logic       af;
    logic [4:0] lvl;
    logic       ovf;
    logic       step;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       winc;
  logic [4:0] rptr_gray;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       overflow;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_n  = 0;

  wptr_full_gen #(.ADDR_BITS(4), .AF_LEVEL(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wen          (wen),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .overflow     (overflow)
  );

  // Clock: falling edges at 5, 15, ...; rising edges at 10, 20, ...
  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [4:0] g(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input int cyc, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL c%0d.%s actual=%0h required=%0h", cyc, fld, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected while these inputs are applied.
  task automatic cyc_t(input logic r, input logic w, input logic [4:0] rp, input logic [7:0] m,
                       input logic e_wen, input logic [3:0] e_addr, input logic [4:0] e_gray,
                       input logic e_full, input logic e_af, input logic [4:0] e_lvl,
                       input logic e_ovf, input logic e_step);
    exp_t e;
    rst_n     = r;
    winc      = w;
    rptr_gray = rp;
    e.cyc  = cyc_n;
    e.m    = m;
    e.wen  = e_wen;
    e.addr = e_addr;
    e.gray = e_gray;
    e.full = e_full;
    e.af   = e_af;
    e.lvl  = e_lvl;
    e.ovf  = e_ovf;
    e.step = e_step;
    sb_q.push_back(e);
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares one queued expectation per falling edge and tracks Gray steps.
  initial begin
    exp_t       e;
    logic [4:0] prev_gray;
    prev_gray = 5'b00000;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if ((e.m & M_WEN)  != 8'h00) chk(e.cyc, "wen",          32'(wen),          32'(e.wen));
        if ((e.m & M_ADDR) != 8'h00) chk(e.cyc, "waddr",        32'(waddr),        32'(e.addr));
        if ((e.m & M_GRAY) != 8'h00) chk(e.cyc, "wptr_gray",    32'(wptr_gray),    32'(e.gray));
        if ((e.m & M_FULL) != 8'h00) chk(e.cyc, "wfull",        32'(wfull),        32'(e.full));
        if ((e.m & M_AF)   != 8'h00) chk(e.cyc, "walmost_full", 32'(walmost_full), 32'(e.af));
        if ((e.m & M_LVL)  != 8'h00) chk(e.cyc, "wlevel",       32'(wlevel),       32'(e.lvl));
        if ((e.m & M_OVF)  != 8'h00) chk(e.cyc, "overflow",     32'(overflow),     32'(e.ovf));
        if ((e.m & M_STEP) != 8'h00) chk(e.cyc, "gray_bits_changed",
                                         32'($countones(wptr_gray ^ prev_gray)), 32'(e.step));
      end
      prev_gray = wptr_gray;
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-derived expectations.
  initial begin
    rst_n     = 1'b0;
    winc      = 1'b0;
    rptr_gray = 5'b00000;
    #1;

    // Reset held for two edges with winc=1: nothing written, all state zero.
    cyc_t(1'b0, 1'b1, 5'b00000, M_WEN | M_ADDR, 1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cyc_t(1'b0, 1'b1, 5'b00000, M_ALL, 1'b0, 4'd0, 5'b00000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Sixteen writes with the read pointer at zero; almost-full after the 14th.
    for (int j = 0; j < 16; j++) begin
      cyc_t(1'b1, 1'b1, 5'b00000, M_ALL, 1'b1, 4'(j), g(j), 1'b0, (j >= 14), 5'(j), 1'b0, 1'b0);
    end

    // Full: the write attempt is dropped and raises overflow.
    cyc_t(1'b1, 1'b1, 5'b00000, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc_t(1'b1, 1'b0, 5'b00000, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    end

    // Read pointer advances by one; full clears on the third edge.
    cyc_t(1'b1, 1'b0, 5'b00001, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    cyc_t(1'b1, 1'b0, 5'b00001, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    // Write attempted while still flagged full: dropped, no look-ahead.
    cyc_t(1'b1, 1'b1, 5'b00001, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    cyc_t(1'b1, 1'b0, 5'b00001, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0);

    // Reset clears everything, including the sticky overflow.
    cyc_t(1'b0, 1'b1, 5'b00000, M_ALL, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0);
    for (int j = 0; j < 9; j++) begin
      cyc_t(1'b1, 1'b1, 5'b00000, M_ALL, 1'b1, 4'(j), g(j), 1'b0, 1'b0, 5'(j), 1'b0, 1'b0);
    end

    // Reset mid-stream at level 9 with winc=1.
    cyc_t(1'b0, 1'b1, 5'b00000, M_ALL, 1'b0, 4'd0, 5'b01101, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);

    // Forty writes with the read pointer tracking the write pointer; level settles at 3.
    for (int n = 0; n < 40; n++) begin
      cyc_t(1'b1, 1'b1, g(n), (n > 0) ? (M_ALL | M_STEP) : M_ALL,
            1'b1, 4'(n % 16), g(n % 32), 1'b0, 1'b0, 5'((n < 3) ? n : 3), 1'b0, 1'b1);
    end

    // Idle: pointer holds, level drains as the synchronized read pointer catches up.
    cyc_t(1'b1, 1'b0, g(8), M_ALL | M_STEP, 1'b0, 4'd8, 5'b01100, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1);
    cyc_t(1'b1, 1'b0, g(8), M_ALL | M_STEP, 1'b0, 4'd8, 5'b01100, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
    cyc_t(1'b1, 1'b0, g(8), M_ALL | M_STEP, 1'b0, 4'd8, 5'b01100, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0);
    cyc_t(1'b1, 1'b0, g(8), M_ALL | M_STEP, 1'b0, 4'd8, 5'b01100, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    chk(cyc_n, "scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
